// File: rtl/pooling_window_buffer_pkg.sv
`default_nettype none
// ============================================================================
// pooling_window_buffer_pkg : shared window layout constants and row-phase FSM type
// Revision: 1.0
// ============================================================================
package pooling_window_buffer_pkg;

  localparam int c_WIN_SIZE = 4;
  localparam int c_WIN_TL   = 0;
  localparam int c_WIN_TR   = 1;
  localparam int c_WIN_BL   = 2;
  localparam int c_WIN_BR   = 3;

  typedef enum logic [0:0] {
    TOP_ROW    = 1'b0,
    BOTTOM_ROW = 1'b1
  } row_state_e;

endpackage
`default_nettype wire

// File: rtl/pooling_window_buffer_line.sv
`default_nettype none
// ============================================================================
// pooling_line_buffer : one-row store, one synchronous write, two async reads
// Revision: 1.0
// ============================================================================
module pooling_line_buffer #(
  parameter int I_WIDTH = 8,
  parameter int DEPTH   = 4,
  parameter int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk,
  input  logic               i_we,
  input  logic [AW-1:0]      i_waddr,
  input  logic [I_WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]      i_raddr0,
  output logic [I_WIDTH-1:0] o_rdata0,
  input  logic [AW-1:0]      i_raddr1,
  output logic [I_WIDTH-1:0] o_rdata1
);

  logic [I_WIDTH-1:0] r_mem [DEPTH];

  // Every location is written in the top row before the bottom row reads it.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata0 = r_mem[i_raddr0];
  assign o_rdata1 = r_mem[i_raddr1];

endmodule
`default_nettype wire

// File: rtl/pooling_window_buffer.sv
`default_nettype none
// ============================================================================
// pooling_window_buffer : groups a raster stream into non-overlapping 2x2 windows
// Revision: 1.0
// ============================================================================
module pooling_window_buffer
  import pooling_window_buffer_pkg::*;
#(
  parameter int I_WIDTH    = 8,
  parameter int IMG_WIDTH  = 4,
  parameter int IMG_HEIGHT = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [I_WIDTH-1:0]            input_data,
  input  logic                          input_valid,
  output logic [c_WIN_SIZE*I_WIDTH-1:0] output_data,
  output logic                          output_valid,
  output logic                          frame_done
);

  localparam int c_CW = $clog2(IMG_WIDTH);
  localparam int c_RW = $clog2(IMG_HEIGHT);
  localparam logic [c_CW-1:0] c_LAST_COL = c_CW'(IMG_WIDTH - 1);
  localparam logic [c_RW-1:0] c_LAST_ROW = c_RW'(IMG_HEIGHT - 1);

  if ((IMG_WIDTH < 2) || ((IMG_WIDTH % 2) != 0)) begin : g_bad_width
    $error("pooling_window_buffer: IMG_WIDTH must be even and >= 2");
  end
  if ((IMG_HEIGHT < 2) || ((IMG_HEIGHT % 2) != 0)) begin : g_bad_height
    $error("pooling_window_buffer: IMG_HEIGHT must be even and >= 2");
  end

  row_state_e                    r_state;
  logic [c_CW-1:0]               r_col;
  logic [c_RW-1:0]               r_row;
  logic [I_WIDTH-1:0]            r_bl;
  logic [c_WIN_SIZE*I_WIDTH-1:0] r_out_data;
  logic                          r_out_valid;
  logic                          r_frame_done;

  logic                          w_last_col;
  logic                          w_last_row;
  logic                          w_lb_we;
  logic [c_CW-1:0]               w_raddr_left;
  logic [I_WIDTH-1:0]            w_line_left;
  logic [I_WIDTH-1:0]            w_line_right;

  assign w_last_col   = (r_col == c_LAST_COL);
  assign w_last_row   = (r_row == c_LAST_ROW);
  assign w_lb_we      = input_valid && (r_state == TOP_ROW);
  // Left partner of an odd column is the same index with bit 0 cleared.
  assign w_raddr_left = r_col & ~c_CW'(1);

  pooling_line_buffer #(
    .I_WIDTH (I_WIDTH),
    .DEPTH   (IMG_WIDTH),
    .AW      (c_CW)
  ) u_line (
    .clk      (clk),
    .i_we     (w_lb_we),
    .i_waddr  (r_col),
    .i_wdata  (input_data),
    .i_raddr0 (w_raddr_left),
    .o_rdata0 (w_line_left),
    .i_raddr1 (r_col),
    .o_rdata1 (w_line_right)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= TOP_ROW;
      r_col        <= '0;
      r_row        <= '0;
      r_bl         <= '0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      if (input_valid) begin
        if (w_last_col) begin
          r_col <= '0;
          r_row <= w_last_row ? '0 : r_row + c_RW'(1);
        end else begin
          r_col <= r_col + c_CW'(1);
        end

        case (r_state)
          TOP_ROW: begin
            if (w_last_col) begin
              r_state <= BOTTOM_ROW;
            end
          end
          BOTTOM_ROW: begin
            if (!r_col[0]) begin
              r_bl <= input_data;
            end else begin
              r_out_data[I_WIDTH*c_WIN_TL +: I_WIDTH] <= w_line_left;
              r_out_data[I_WIDTH*c_WIN_TR +: I_WIDTH] <= w_line_right;
              r_out_data[I_WIDTH*c_WIN_BL +: I_WIDTH] <= r_bl;
              r_out_data[I_WIDTH*c_WIN_BR +: I_WIDTH] <= input_data;
              r_out_valid  <= 1'b1;
              r_frame_done <= w_last_col && w_last_row;
            end
            if (w_last_col) begin
              r_state <= TOP_ROW;
            end
          end
          default: r_state <= TOP_ROW;
        endcase
      end
    end
  end

  assign output_data  = r_out_data;
  assign output_valid = r_out_valid;
  assign frame_done   = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_pooling_window_buffer.sv
`default_nettype none
// ============================================================================
// tb_pooling_window_buffer : image-level reference model plus directed windows
// Revision: 1.0
// ============================================================================
module tb_pooling_window_buffer;

  localparam int IW = 8;
  localparam int W  = 4;
  localparam int H  = 4;

  logic            clk;
  logic            rst;
  logic [IW-1:0]   input_data;
  logic            input_valid;
  logic [4*IW-1:0] output_data;
  logic            output_valid;
  logic            frame_done;

  int n_cmp = 0;
  int n_err = 0;

  pooling_window_buffer #(
    .I_WIDTH    (IW),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .input_data   (input_data),
    .input_valid  (input_valid),
    .output_data  (output_data),
    .output_valid (output_valid),
    .frame_done   (frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: remember the whole current image, emit a window at each odd/odd pixel.
  logic [IW-1:0]   img [H][W];
  int              m_row;
  int              m_col;
  logic            exp_valid;
  logic            exp_fd;
  logic [4*IW-1:0] exp_data;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_row     <= 0;
      m_col     <= 0;
      exp_valid <= 1'b0;
      exp_fd    <= 1'b0;
      exp_data  <= '0;
    end else begin
      exp_valid <= 1'b0;
      exp_fd    <= 1'b0;
      if (input_valid) begin
        img[m_row][m_col] <= input_data;
        if ((m_row % 2 == 1) && (m_col % 2 == 1)) begin
          exp_valid <= 1'b1;
          exp_data  <= {input_data, img[m_row][m_col-1],
                        img[m_row-1][m_col], img[m_row-1][m_col-1]};
          exp_fd    <= (m_row == H-1) && (m_col == W-1);
        end
        if (m_col == W-1) begin
          m_col <= 0;
          m_row <= (m_row == H-1) ? 0 : m_row + 1;
        end else begin
          m_col <= m_col + 1;
        end
      end
    end
  end

  logic [4*IW-1:0] cap_q [$];
  int              cap_fd = 0;
  int              valid_in_rst = 0;

  always @(negedge clk) begin
    n_cmp = n_cmp + 3;
    if (output_valid !== exp_valid) begin
      n_err = n_err + 1;
      $display("FAIL output_valid @%0t: got %b expected %b", $time, output_valid, exp_valid);
    end
    if (frame_done !== exp_fd) begin
      n_err = n_err + 1;
      $display("FAIL frame_done @%0t: got %b expected %b", $time, frame_done, exp_fd);
    end
    if (output_data !== exp_data) begin
      n_err = n_err + 1;
      $display("FAIL output_data @%0t: got %h expected %h", $time, output_data, exp_data);
    end
    if (output_valid === 1'b1) begin
      cap_q.push_back(output_data);
      if (rst) valid_in_rst = valid_in_rst + 1;
    end
    if (frame_done === 1'b1) cap_fd = cap_fd + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [4*IW-1:0] cap_at(input int i);
    return (i < cap_q.size()) ? cap_q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic clear_cap();
    cap_q.delete();
    cap_fd = 0;
    valid_in_rst = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [IW-1:0] d, input int gap);
    input_valid = 1'b1;
    input_data  = d;
    @(posedge clk);
    #1;
    input_valid = 1'b0;
    input_data  = IW'($urandom);
    idle(gap);
  endtask

  task automatic check_ref_frame(input string tag);
    check({tag, "_count"}, cap_q.size(), 4);
    check({tag, "_w0"}, cap_at(0), 32'h0504_0100);
    check({tag, "_w1"}, cap_at(1), 32'h0706_0302);
    check({tag, "_w2"}, cap_at(2), 32'h0D0C_0908);
    check({tag, "_w3"}, cap_at(3), 32'h0F0E_0B0A);
    check({tag, "_fd"}, cap_fd, 1);
  endtask

  initial begin
    bit did_rst;
    rst         = 1'b1;
    input_valid = 1'b0;
    input_data  = '0;
    idle(3);
    check("reset_data", output_data, 32'h0);
    check("reset_valid", {31'b0, output_valid}, 32'h0);
    check("reset_fd", {31'b0, frame_done}, 32'h0);
    rst = 1'b0;
    idle(1);

    clear_cap();
    for (int i = 0; i < 16; i++) send(IW'(i), 0);
    idle(3);
    check_ref_frame("cont");

    clear_cap();
    for (int i = 0; i < 16; i++) send(IW'(i), 3);
    idle(3);
    check_ref_frame("gap3");

    clear_cap();
    for (int i = 0; i < 32; i++) send(IW'(i), 0);
    idle(3);
    check("b2b_count", cap_q.size(), 8);
    check("b2b_fd", cap_fd, 2);
    check("b2b_w4", cap_at(4), 32'h1514_1110);
    check("b2b_w7", cap_at(7), 32'h1F1E_1B1A);

    for (int i = 0; i < 7; i++) send(IW'(i), 0);
    rst = 1'b1;
    clear_cap();
    idle(3);
    rst = 1'b0;
    idle(1);
    check("rst_quiet", valid_in_rst, 0);
    check("rst_quiet_count", cap_q.size(), 0);
    for (int i = 0; i < 16; i++) send(IW'(i), 0);
    idle(3);
    check_ref_frame("post_rst");

    clear_cap();
    for (int i = 0; i < 16; i++) send((i == 5) ? 8'h00 : 8'hFF, 0);
    idle(3);
    check("ff_w0", cap_at(0), 32'h00FF_FFFF);
    check("ff_w1", cap_at(1), 32'hFFFF_FFFF);
    check("ff_w2", cap_at(2), 32'hFFFF_FFFF);
    check("ff_w3", cap_at(3), 32'hFFFF_FFFF);

    clear_cap();
    did_rst = 1'b0;
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < W*H; i++) begin
        if (f == 3 && i == 9 && !did_rst) begin
          did_rst = 1'b1;
          rst = 1'b1;
          idle($urandom_range(1, 3));
          rst = 1'b0;
          break;
        end
        send(IW'($urandom), ($urandom_range(0, 9) < 6) ? 0 : $urandom_range(1, 4));
      end
    end
    idle(4);
    check("rand_fd", cap_fd, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pooling_window_buffer.md
POOLING_WINDOW_BUFFER -- requirements
Module: pooling_window_buffer

Interface
REQ-001 Parameter I_WIDTH, default 8: bit width of one feature-map element.
REQ-002 Parameter IMG_WIDTH, default 4: elements per input row; must be even and >= 2.
REQ-003 Parameter IMG_HEIGHT, default 4: rows per frame; must be even and >= 2.
REQ-004 Port clk  input  1: single clock; all state SHALL update on its rising edge.
REQ-005 Port rst  input  1: asynchronous, active-high reset.
REQ-006 Port input_data  input  I_WIDTH: one element, raster order (row-major, left to right, top to bottom).
REQ-007 Port input_valid  input  1: input_data is accepted on every rising edge where this is high; there is no backpressure.
REQ-008 Port output_data  output  4*I_WIDTH: one 2x2 window, element k at bits [I_WIDTH*k +: I_WIDTH]; k=0 top-left, 1 top-right, 2 bottom-left, 3 bottom-right; directly consumable by a max-pooling unit with SIZE=4.
REQ-009 Port output_valid  output  1: one-cycle pulse marking output_data as a new window.
REQ-010 Port frame_done  output  1: one-cycle pulse coincident with the last window of a frame.

Function
REQ-011 The block SHALL form non-overlapping 2x2 windows, stride 2, emitting (IMG_WIDTH/2)*(IMG_HEIGHT/2) windows per frame.
REQ-012 The block SHALL keep a column counter (0..IMG_WIDTH-1) and a row counter (0..IMG_HEIGHT-1) that advance only on accepted elements.
REQ-013 FSM states: TOP_ROW (even row) and BOTTOM_ROW (odd row); TOP_ROW -> BOTTOM_ROW on acceptance at column IMG_WIDTH-1; BOTTOM_ROW -> TOP_ROW on acceptance at column IMG_WIDTH-1.
REQ-014 In TOP_ROW each accepted element SHALL be written to the line buffer at index = column.
REQ-015 In BOTTOM_ROW an accepted element at an even column SHALL be held in a bottom-left register.
REQ-016 In BOTTOM_ROW an accepted element at odd column c SHALL produce window {line[c-1], line[c], bottom-left register, input_data} in element order 0..3.
REQ-017 output_data and output_valid SHALL be registered: latency exactly one cycle from acceptance of the bottom-right element.
REQ-018 output_data SHALL hold its last value while output_valid is low.
REQ-019 frame_done SHALL pulse in the same cycle as output_valid for the window whose bottom-right element is at row IMG_HEIGHT-1, column IMG_WIDTH-1.
REQ-020 After the last element of a frame both counters SHALL wrap to 0 and the FSM SHALL return to TOP_ROW, so a following frame can start on the next cycle.
REQ-021 Cycles with input_valid low SHALL leave all state unchanged and output_valid low; gaps of any length SHALL be tolerated anywhere in the frame.
REQ-022 Element values SHALL be passed through unmodified; no arithmetic or saturation is applied.

Reset
REQ-023 While rst is high: counters = 0, FSM = TOP_ROW, output_data = 0, output_valid = 0, frame_done = 0, bottom-left register = 0.
REQ-024 Line buffer contents SHALL need no reset; they are always written before being read.
REQ-025 Reset asserted mid-frame SHALL discard the partial frame; the first accepted element after release is treated as row 0, column 0.

Structure
REQ-026 Window element index constants (TL=0, TR=1, BL=2, BR=3) and the window size 4 SHALL live in the common definitions include.
REQ-027 The line buffer SHALL be a sub-module, pooling_line_buffer (IMG_WIDTH x I_WIDTH, one synchronous write port, two asynchronous read ports).
REQ-028 Parameter legality (even, >= 2) SHALL be checked at elaboration.

Verification
REQ-029 4x4 frame, values 0..15, continuous valid -> windows {0,1,4,5}, {2,3,6,7}, {8,9,12,13}, {10,11,14,15}, each one cycle after elements 5, 7, 13, 15; frame_done only with the last window.
REQ-030 Same frame with input_valid low for 3 cycles after every element -> identical windows; output_valid pulses last one cycle each.
REQ-031 Two back-to-back 4x4 frames (second frame = values 16..31) -> 8 windows, frame_done pulsed twice, second frame's first window {16,17,20,21}.
REQ-032 rst asserted after element 6 of a frame, then a full frame 0..15 -> no output during reset; the four windows of REQ-029 follow.
REQ-033 I_WIDTH=8, all elements 8'hFF except one 8'h00 -> that window carries the 8'h00 in the correct element slot, with no corruption of neighbouring slots.
